jtag_tap_controller: RTL and testbench
======================================

Name: jtag_tap_controller

Overview:
- Device-side JTAG test access port, the target end of the link driven by the simulated JTAG host.
- Oversamples TCK/TMS/TDI/TRST in the core clk domain and runs the IEEE 1149.1 16-state TAP FSM.
- Holds the instruction register, IDCODE and BYPASS registers, and a generic data register.
- Gives the on-chip debug controller capture/update strobes so it can exchange one DR word per scan.

Parameters:
- IR_WIDTH, 4: instruction register width, bits; must be ≥ 2.
- DR_WIDTH, 32: generic data register width, bits; must be ≥ 2.
- IDCODE_VALUE, 32'h4e20_7d1f: value captured for INST_IDCODE.
- INST_IDCODE, 4'h1: IDCODE opcode; also the reset instruction.
- INST_BYPASS, 4'hf: BYPASS opcode.

Ports:
- clk  in  1  core clock; must run ≥ 8× TCK.
- reset  in  1  asynchronous, active-high.
- jtag_tck  in  1  TCK from host; asynchronous.
- jtag_tms  in  1  TMS from host.
- jtag_tdi  in  1  serial data from host to device.
- jtag_trst  in  1  test reset, active-high; synchronized to clk.
- jtag_tdo  out  1  serial data from device to host.
- instruction  out  IR_WIDTH  current instruction.
- data_capture_val  in  DR_WIDTH  value loaded into the DR shifter in Capture-DR for user instructions.
- data_capture  out  1  one-clk pulse on Capture-DR, user instructions only.
- data_update  out  1  one-clk pulse on Update-DR, user instructions only.
- data_update_val  out  DR_WIDTH  shifted-in DR value; valid while data_update is high.
- tap_state  out  4  current TAP state, for debug and the bench.

Behaviour:
- Reset: reset is asynchronous, active-high; clock is clk.
  - On reset: state = TEST_LOGIC_RESET, instruction = INST_IDCODE, jtag_tdo = 0, all strobes 0, shifters 0, synchronizer flops 0.
- Synchronization:
  - jtag_tck, jtag_tms, jtag_tdi and jtag_trst each pass through a 2-flop synchronizer.
  - A third tck flop supplies edge detection.
  - TCK rise/fall is acted on 3 clk after the pin edge.
  - TMS/TDI are sampled from the synchronized copies in the same cycle the rise is detected.
- TAP FSM:
  - Advances only on a detected TCK rise, following standard IEEE 1149.1 transitions on the sampled TMS.
  - States: TEST_LOGIC_RESET, RUN_TEST_IDLE, SELECT_DR, CAPTURE_DR, SHIFT_DR, EXIT1_DR, PAUSE_DR, EXIT2_DR, UPDATE_DR, SELECT_IR, CAPTURE_IR, SHIFT_IR, EXIT1_IR, PAUSE_IR, EXIT2_IR, UPDATE_IR.
  - Five consecutive rises with TMS=1 reach TEST_LOGIC_RESET from any state.
  - Synchronized trst=1 forces TEST_LOGIC_RESET and instruction = INST_IDCODE, overriding any TCK edge in the same cycle.
  - While in TEST_LOGIC_RESET, instruction is held at INST_IDCODE.
- Register actions happen on a TCK rise and are based on the state being left:
  - CAPTURE_IR: ir_shift = {zeros, 2'b01}.
  - SHIFT_IR: ir_shift = {tdi, ir_shift[IR_WIDTH-1:1]}.
  - UPDATE_IR: instruction = ir_shift.
  - CAPTURE_DR:
    - IDCODE: dr_shift = IDCODE_VALUE.
    - BYPASS: bypass_ff = 0.
    - Otherwise: dr_shift = data_capture_val, with data_capture pulsed. data_capture_val is sampled in the capture cycle, not before.
  - SHIFT_DR:
    - BYPASS: bypass_ff = tdi.
    - Otherwise: dr_shift = {tdi, dr_shift[DR_WIDTH-1:1]}.
  - UPDATE_DR, user instruction: data_update pulses for 1 clk and data_update_val = dr_shift.
    - The value holds until the next update.
    - IDCODE/BYPASS updates produce no pulse.
- TDO is updated on a detected TCK fall:
  - SHIFT_IR: ir_shift[0].
  - SHIFT_DR: dr_shift[0], or bypass_ff under BYPASS.
  - All other states: 0.
- Shift length: the host may shift more or fewer bits than the register width.
  - Extra bits flow through; the LSB-side bits are lost.
  - Fewer bits leave a partially shifted value.
  - No error is flagged.
- PAUSE states hold the shifters unchanged.
- Reset mid-scan aborts the scan with no update pulse.
- A TCK glitch shorter than 2 clk may be missed; this is a documented constraint, not handled.

Decomposition:
- Package jtag_pkg holds:
  - typedef enum logic[3:0] tap_state_t, shared with the host testbench;
  - default opcode localparams.
- One sub-module, jtag_sync_edge: 2-flop synchronizer plus rise/fall pulse generator, instantiated for tck. Plain synchronizers cover tms/tdi/trst.

Test Plan:
- Reset, then TMS=0 for 1 TCK → tap_state = RUN_TEST_IDLE; instruction = 4'h1; jtag_tdo = 0.
- Default IDCODE DR scan of 32 bits with TDI=0 → the host collects 32'h4e20_7d1f LSB-first; no data_update pulse.
- IR scan of 4'h2, then DR scan with data_capture_val = 32'hdead_beef and TDI shifting 32'h1234_5678:
  - data_capture pulses once;
  - TDO streams 32'hdead_beef;
  - data_update pulses once with data_update_val = 32'h1234_5678.
- IR scan shifting 4'h3 reads back 4'b0001 on TDO → capture pattern confirmed; instruction = 4'h3 after UPDATE_IR.
- BYPASS (4'hf), then shift 8 bits 8'ha5 → TDO returns 8'ha5 delayed by one bit (first bit 0).
- Mid-SHIFT_DR assert jtag_trst, or hold TMS=1 for 5 TCK → TEST_LOGIC_RESET; instruction = 4'h1; no data_update pulse.

Source files
------------

// File: rtl/jtag_pkg.sv
// Shared JTAG TAP definitions: state encoding, default opcodes and the
// standard TMS-driven state transition function.
package jtag_pkg;

    typedef enum logic [3:0] {
        TEST_LOGIC_RESET = 4'd0,
        RUN_TEST_IDLE    = 4'd1,
        SELECT_DR        = 4'd2,
        CAPTURE_DR       = 4'd3,
        SHIFT_DR         = 4'd4,
        EXIT1_DR         = 4'd5,
        PAUSE_DR         = 4'd6,
        EXIT2_DR         = 4'd7,
        UPDATE_DR        = 4'd8,
        SELECT_IR        = 4'd9,
        CAPTURE_IR       = 4'd10,
        SHIFT_IR         = 4'd11,
        EXIT1_IR         = 4'd12,
        PAUSE_IR         = 4'd13,
        EXIT2_IR         = 4'd14,
        UPDATE_IR        = 4'd15
    } tap_state_t;

    localparam int unsigned DEFAULT_IR_WIDTH    = 4;
    localparam int unsigned DEFAULT_DR_WIDTH    = 32;
    localparam logic [31:0] DEFAULT_IDCODE      = 32'h4e20_7d1f;
    localparam logic [3:0]  DEFAULT_INST_IDCODE = 4'h1;
    localparam logic [3:0]  DEFAULT_INST_BYPASS = 4'hf;

    // IEEE 1149.1 TAP transition taken on a TCK rise with the sampled TMS.
    function automatic tap_state_t tap_next(input tap_state_t s, input logic tms);
        tap_state_t nxt;
        nxt = TEST_LOGIC_RESET;
        case (s)
            TEST_LOGIC_RESET: nxt = tms ? TEST_LOGIC_RESET : RUN_TEST_IDLE;
            RUN_TEST_IDLE:    nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_DR:        nxt = tms ? SELECT_IR        : CAPTURE_DR;
            CAPTURE_DR:       nxt = tms ? EXIT1_DR         : SHIFT_DR;
            SHIFT_DR:         nxt = tms ? EXIT1_DR         : SHIFT_DR;
            EXIT1_DR:         nxt = tms ? UPDATE_DR        : PAUSE_DR;
            PAUSE_DR:         nxt = tms ? EXIT2_DR         : PAUSE_DR;
            EXIT2_DR:         nxt = tms ? UPDATE_DR        : SHIFT_DR;
            UPDATE_DR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            SELECT_IR:        nxt = tms ? TEST_LOGIC_RESET : CAPTURE_IR;
            CAPTURE_IR:       nxt = tms ? EXIT1_IR         : SHIFT_IR;
            SHIFT_IR:         nxt = tms ? EXIT1_IR         : SHIFT_IR;
            EXIT1_IR:         nxt = tms ? UPDATE_IR        : PAUSE_IR;
            PAUSE_IR:         nxt = tms ? EXIT2_IR         : PAUSE_IR;
            EXIT2_IR:         nxt = tms ? UPDATE_IR        : SHIFT_IR;
            UPDATE_IR:        nxt = tms ? SELECT_DR        : RUN_TEST_IDLE;
            default:          nxt = TEST_LOGIC_RESET;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jtag_sync_edge.sv
// Two-flop synchronizer for an asynchronous pin plus a third flop that
// turns the synchronized level into single-clk rise/fall pulses.
module jtag_sync_edge (
    input  logic clk,
    input  logic reset,
    input  logic din,
    output logic rise_c,
    output logic fall_c
);

    logic [2:0] sync_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], din};
        end
    end

    assign rise_c = sync_q[1] & ~sync_q[2];
    assign fall_c = ~sync_q[1] & sync_q[2];

endmodule

// File: rtl/jtag_tap_controller.sv
// Device-side JTAG TAP: oversampled pins, 16-state TAP FSM, IR/IDCODE/BYPASS
// and a generic DR with capture/update strobes for the debug controller.
module jtag_tap_controller
    import jtag_pkg::*;
#(
    parameter int unsigned          IR_WIDTH     = DEFAULT_IR_WIDTH,
    parameter int unsigned          DR_WIDTH     = DEFAULT_DR_WIDTH,
    parameter logic [31:0]          IDCODE_VALUE = DEFAULT_IDCODE,
    parameter logic [IR_WIDTH-1:0]  INST_IDCODE  = IR_WIDTH'(DEFAULT_INST_IDCODE),
    parameter logic [IR_WIDTH-1:0]  INST_BYPASS  = IR_WIDTH'(DEFAULT_INST_BYPASS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                jtag_tck,
    input  logic                jtag_tms,
    input  logic                jtag_tdi,
    input  logic                jtag_trst,
    output logic                jtag_tdo,
    output logic [IR_WIDTH-1:0] instruction,
    input  logic [DR_WIDTH-1:0] data_capture_val,
    output logic                data_capture,
    output logic                data_update,
    output logic [DR_WIDTH-1:0] data_update_val,
    output logic [3:0]          tap_state
);

    logic tck_rise_c;
    logic tck_fall_c;

    logic [1:0] tms_sync;
    logic [1:0] tdi_sync;
    logic [1:0] trst_sync;
    logic       tms_s;
    logic       tdi_s;
    logic       trst_s;

    tap_state_t state_q;
    tap_state_t state_d;

    logic [IR_WIDTH-1:0] ir_shift;
    logic [DR_WIDTH-1:0] dr_shift;
    logic                bypass_ff;
    logic                is_idcode;
    logic                is_bypass;
    logic                is_user;

    jtag_sync_edge u_tck_sync (
        .clk    (clk),
        .reset  (reset),
        .din    (jtag_tck),
        .rise_c (tck_rise_c),
        .fall_c (tck_fall_c)
    );

    // Level synchronizers; same depth as tck so TMS/TDI line up with the rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tms_sync  <= '0;
            tdi_sync  <= '0;
            trst_sync <= '0;
        end else begin
            tms_sync  <= {tms_sync[0], jtag_tms};
            tdi_sync  <= {tdi_sync[0], jtag_tdi};
            trst_sync <= {trst_sync[0], jtag_trst};
        end
    end

    assign tms_s  = tms_sync[1];
    assign tdi_s  = tdi_sync[1];
    assign trst_s = trst_sync[1];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= TEST_LOGIC_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (trst_s) begin
            state_d = TEST_LOGIC_RESET;
        end else if (tck_rise_c) begin
            state_d = tap_next(state_q, tms_s);
        end
    end

    assign tap_state = state_q;

    assign is_idcode = (instruction == INST_IDCODE);
    assign is_bypass = (instruction == INST_BYPASS);
    assign is_user   = !is_idcode && !is_bypass;

    // Instruction register: actions keyed on the state being left at a rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ir_shift    <= '0;
            instruction <= INST_IDCODE;
        end else if (trst_s || state_q == TEST_LOGIC_RESET) begin
            instruction <= INST_IDCODE;
        end else if (tck_rise_c) begin
            case (state_q)
                CAPTURE_IR: ir_shift    <= IR_WIDTH'(2'b01);
                SHIFT_IR:   ir_shift    <= {tdi_s, ir_shift[IR_WIDTH-1:1]};
                UPDATE_IR:  instruction <= ir_shift;
                default:    ;
            endcase
        end
    end

    // Data registers and the debug-controller strobes.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dr_shift        <= '0;
            bypass_ff       <= 1'b0;
            data_capture    <= 1'b0;
            data_update     <= 1'b0;
            data_update_val <= '0;
        end else begin
            data_capture <= 1'b0;
            data_update  <= 1'b0;
            if (!trst_s && tck_rise_c) begin
                case (state_q)
                    CAPTURE_DR: begin
                        if (is_idcode) begin
                            dr_shift <= DR_WIDTH'(IDCODE_VALUE);
                        end else if (is_bypass) begin
                            bypass_ff <= 1'b0;
                        end else begin
                            dr_shift     <= data_capture_val;
                            data_capture <= 1'b1;
                        end
                    end
                    SHIFT_DR: begin
                        if (is_bypass) begin
                            bypass_ff <= tdi_s;
                        end else begin
                            dr_shift <= {tdi_s, dr_shift[DR_WIDTH-1:1]};
                        end
                    end
                    UPDATE_DR: begin
                        if (is_user) begin
                            data_update     <= 1'b1;
                            data_update_val <= dr_shift;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // TDO changes on the TCK fall so the host can sample it on the next rise.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_tdo <= 1'b0;
        end else if (trst_s) begin
            jtag_tdo <= 1'b0;
        end else if (tck_fall_c) begin
            case (state_q)
                SHIFT_IR: jtag_tdo <= ir_shift[0];
                SHIFT_DR: jtag_tdo <= is_bypass ? bypass_ff : dr_shift[0];
                default:  jtag_tdo <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_jtag_tap_controller.sv
// Randomized scoreboard bench for jtag_tap_controller: a host task drives
// TCK/TMS/TDI, a scan-level model predicts results, a monitor compares.
module tb_jtag_tap_controller;
    import jtag_pkg::*;

    localparam int unsigned IRW  = 4;
    localparam int unsigned DRW  = 32;
    localparam int          HALF = 80;
    localparam logic [31:0] IDC  = 32'h4e20_7d1f;

    logic            clk;
    logic            reset;
    logic            jtag_tck;
    logic            jtag_tms;
    logic            jtag_tdi;
    logic            jtag_trst;
    logic            jtag_tdo;
    logic [IRW-1:0]  instruction;
    logic [DRW-1:0]  data_capture_val;
    logic            data_capture;
    logic            data_update;
    logic [DRW-1:0]  data_update_val;
    logic [3:0]      tap_state;

    jtag_tap_controller dut (
        .clk              (clk),
        .reset            (reset),
        .jtag_tck         (jtag_tck),
        .jtag_tms         (jtag_tms),
        .jtag_tdi         (jtag_tdi),
        .jtag_trst        (jtag_trst),
        .jtag_tdo         (jtag_tdo),
        .instruction      (instruction),
        .data_capture_val (data_capture_val),
        .data_capture     (data_capture),
        .data_update      (data_update),
        .data_update_val  (data_update_val),
        .tap_state        (tap_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef enum int {K_STATE, K_INSTR, K_TDO} kind_t;
    typedef struct {
        kind_t       kind;
        logic [31:0] exp;
    } snap_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    snap_t       snap_q[$];
    int          exp_cap_q[$];
    logic [31:0] exp_upd_q[$];
    logic [63:0] exp_tdo_q[$];
    logic [63:0] act_tdo_q[$];
    logic [3:0]  m_instr;

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endfunction

    // Monitor: compares whenever the DUT strobes or the host hands over an observation.
    always @(negedge clk) begin
        if (!reset) begin
            if (data_capture) begin
                n_cmp++;
                if (exp_cap_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL capture_pulse: got pulse, expected none");
                end else begin
                    void'(exp_cap_q.pop_front());
                end
            end
            if (data_update) begin
                if (exp_upd_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL update_pulse: got pulse val %h, expected none", data_update_val);
                end else begin
                    check("update_val", 64'(data_update_val), 64'(exp_upd_q.pop_front()));
                end
            end
            while (snap_q.size() > 0) begin
                snap_t s;
                s = snap_q.pop_front();
                case (s.kind)
                    K_STATE: check("tap_state", 64'(tap_state), 64'(s.exp));
                    K_INSTR: check("instruction", 64'(instruction), 64'(s.exp));
                    default: check("tdo_pin", 64'(jtag_tdo), 64'(s.exp));
                endcase
            end
            while (exp_tdo_q.size() > 0 && act_tdo_q.size() > 0) begin
                check("tdo_stream", act_tdo_q.pop_front(), exp_tdo_q.pop_front());
            end
        end
    end

    // Scan-level model: register of width w preloaded with c, n bits of tdi shifted in LSB-first.
    function automatic logic [127:0] stream_of(input int w, input logic [63:0] c, input logic [63:0] tdi);
        logic [127:0] t;
        t = {64'b0, tdi} << w;
        return t | {64'b0, c};
    endfunction

    function automatic logic [63:0] mask(input int n);
        return (n >= 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    task automatic tck_bit(input logic tms, input logic tdi, output logic tdo);
        jtag_tms = tms;
        jtag_tdi = tdi;
        #HALF;
        tdo = jtag_tdo;
        jtag_tck = 1'b1;
        #HALF;
        jtag_tck = 1'b0;
    endtask

    task automatic tick(input logic tms);
        logic unused;
        tck_bit(tms, 1'b0, unused);
    endtask

    task automatic snap(input kind_t k, input logic [31:0] e);
        snap_t s;
        s.kind = k;
        s.exp  = e;
        snap_q.push_back(s);
    endtask

    task automatic settle_and_check(input tap_state_t st, input logic [3:0] ins);
        #50;
        snap(K_STATE, 32'(st));
        snap(K_INSTR, 32'(ins));
        snap(K_TDO, 32'd0);
        #20;
    endtask

    // From RUN_TEST_IDLE: full IR or DR scan, optional pause, ends back in RUN_TEST_IDLE.
    task automatic do_scan(input bit is_ir, input int n, input logic [63:0] tdi, input int pause_at,
                           input logic [31:0] cap, output logic [63:0] tdo);
        logic b;
        logic last;
        tdo = '0;
        data_capture_val = ~cap;
        tick(1'b1);
        if (is_ir) tick(1'b1);
        tick(1'b0);
        data_capture_val = cap;
        tick(1'b0);
        data_capture_val = 32'($urandom());
        for (int i = 0; i < n; i++) begin
            last = (i == n - 1) || (i + 1 == pause_at);
            tck_bit(last, tdi[i], b);
            tdo[i] = b;
            if (i + 1 == pause_at && i != n - 1) begin
                tick(1'b0); tick(1'b0); tick(1'b0); tick(1'b1); tick(1'b0);
            end
        end
        tick(1'b1);
        tick(1'b0);
    endtask

    task automatic ir_op(input int n, input logic [63:0] tdi, input int pause_at);
        logic [127:0] s;
        logic [63:0]  got;
        s = stream_of(IRW, 64'h1, tdi & mask(n));
        exp_tdo_q.push_back(s[63:0] & mask(n));
        do_scan(1'b1, n, tdi, pause_at, 32'h0, got);
        act_tdo_q.push_back(got);
        m_instr = 4'(s >> n);
        settle_and_check(RUN_TEST_IDLE, m_instr);
    endtask

    task automatic dr_op(input int n, input logic [63:0] tdi, input logic [31:0] cap, input int pause_at);
        logic [127:0] s;
        logic [63:0]  got;
        int           w;
        logic [63:0]  c;
        bit           user;
        user = (m_instr != 4'h1) && (m_instr != 4'hf);
        if (m_instr == 4'h1) begin
            w = 32; c = 64'(IDC);
        end else if (m_instr == 4'hf) begin
            w = 1;  c = 64'h0;
        end else begin
            w = 32; c = 64'(cap);
        end
        s = stream_of(w, c, tdi & mask(n));
        if (user) begin
            exp_cap_q.push_back(1);
            exp_upd_q.push_back(32'(s >> n));
        end
        exp_tdo_q.push_back(s[63:0] & mask(n));
        do_scan(1'b0, n, tdi, pause_at, cap, got);
        act_tdo_q.push_back(got);
        settle_and_check(RUN_TEST_IDLE, m_instr);
    endtask

    // Abort a DR scan part-way with trst or the async reset: no update may follow.
    task automatic abort_mid_shift(input int k, input bit use_reset);
        if (m_instr != 4'h1 && m_instr != 4'hf) exp_cap_q.push_back(1);
        data_capture_val = 32'($urandom());
        tick(1'b1); tick(1'b0); tick(1'b0);
        for (int i = 0; i < k; i++) tick(1'b0);
        #40;
        if (use_reset) reset = 1'b1; else jtag_trst = 1'b1;
        #60;
        reset = 1'b0;
        jtag_trst = 1'b0;
        m_instr = 4'h1;
        #50;
        snap(K_STATE, 32'(TEST_LOGIC_RESET));
        snap(K_INSTR, 32'h1);
        #20;
        tick(1'b0);
        settle_and_check(RUN_TEST_IDLE, m_instr);
    endtask

    // Five TMS=1 rises from RTI, mid SHIFT_IR, or mid SHIFT_DR (non-user instructions only).
    task automatic tms_reset(input int where, input int k);
        int wh;
        wh = where;
        if (wh == 2 && m_instr != 4'h1 && m_instr != 4'hf) wh = 0;
        if (wh == 1) begin
            tick(1'b1); tick(1'b1); tick(1'b0); tick(1'b0);
            for (int i = 0; i < k; i++) tck_bit(1'b0, 1'($urandom()), jtag_tdi);
        end else if (wh == 2) begin
            tick(1'b1); tick(1'b0); tick(1'b0);
            for (int i = 0; i < k; i++) tick(1'b0);
        end
        for (int i = 0; i < 5; i++) tick(1'b1);
        m_instr = 4'h1;
        settle_and_check(TEST_LOGIC_RESET, 4'h1);
        tick(1'b0);
        settle_and_check(RUN_TEST_IDLE, 4'h1);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        int pa;
        int r;
        logic [3:0] op;
        reset = 1'b1;
        jtag_tck = 1'b0;
        jtag_tms = 1'b0;
        jtag_tdi = 1'b0;
        jtag_trst = 1'b0;
        data_capture_val = '0;
        m_instr = 4'h1;
        #37;
        check("reset_state", 64'(tap_state), 64'(TEST_LOGIC_RESET));
        check("reset_instr", 64'(instruction), 64'h1);
        check("reset_tdo", 64'(jtag_tdo), 64'h0);
        check("reset_strobes", 64'({data_capture, data_update}), 64'h0);
        reset = 1'b0;
        #40;
        tick(1'b0);
        settle_and_check(RUN_TEST_IDLE, 4'h1);

        dr_op(32, 64'h0, 32'h0bad_f00d, 0);
        ir_op(4, 64'h2, 0);
        dr_op(32, 64'h1234_5678, 32'hdead_beef, 0);
        ir_op(4, 64'h3, 0);
        ir_op(4, 64'hf, 0);
        dr_op(8, 64'ha5, 32'h0, 0);
        ir_op(4, 64'h2, 2);
        dr_op(40, 64'h00ab_cdef_0123_4567, 32'h5555_aaaa, 17);
        dr_op(12, 64'h0fed, 32'hcafe_f00d, 0);
        abort_mid_shift(10, 1'b0);
        ir_op(4, 64'h5, 0);
        abort_mid_shift(7, 1'b1);
        tms_reset(0, 0);
        tms_reset(1, 3);
        tms_reset(2, 9);

        for (int it = 0; it < 40; it++) begin
            r = $urandom_range(0, 9);
            if (r < 3) begin
                case ($urandom_range(0, 3))
                    0: op = 4'h1;
                    1: op = 4'hf;
                    default: op = 4'($urandom());
                endcase
                if ($urandom_range(0, 4) == 0) begin
                    n = $urandom_range(1, 8);
                    ir_op(n, {$urandom(), $urandom()}, 0);
                end else begin
                    ir_op(4, 64'(op), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
                end
            end else if (r < 8) begin
                n = $urandom_range(1, 40);
                pa = (n >= 2 && $urandom_range(0, 2) == 0) ? $urandom_range(1, n - 1) : 0;
                dr_op(n, {$urandom(), $urandom()}, 32'($urandom()), pa);
            end else if (r == 8) begin
                abort_mid_shift($urandom_range(0, 20), 1'($urandom()));
            end else begin
                tms_reset($urandom_range(0, 2), $urandom_range(0, 6));
            end
        end

        #200;
        check("pending_captures", 64'(exp_cap_q.size()), 64'd0);
        check("pending_updates", 64'(exp_upd_q.size()), 64'd0);
        check("pending_tdo", 64'(exp_tdo_q.size() + act_tdo_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
